// File: rtl/vga_block_cursor_pkg.sv
// -----------------------------------------------------------------------------
// vga_cursor_pkg
// Shared types and constants for the VGA block cursor.
//   RGB_W  : bits per colour channel
//   rgb_t  : 12-bit colour word laid out as {r, g, b}
//   dir_t  : step direction produced by button arbitration
//   clog2  : ceiling log2, usable in parameter and port width expressions
// -----------------------------------------------------------------------------
package vga_cursor_pkg;

    localparam int RGB_W = 4;

    typedef struct packed {
        logic [RGB_W-1:0] r;
        logic [RGB_W-1:0] g;
        logic [RGB_W-1:0] b;
    } rgb_t;

    typedef enum logic [2:0] {
        DIR_UP,
        DIR_DOWN,
        DIR_LEFT,
        DIR_RIGHT,
        DIR_NONE
    } dir_t;

    // Returns the number of bits needed to index 'value' items (minimum 0).
    function automatic int clog2(input int value);
        int w;
        w = 0;
        while ((1 << w) < value) begin
            w++;
        end
        return w;
    endfunction

endpackage

// File: rtl/vga_block_cursor_if.sv
// -----------------------------------------------------------------------------
// vga_block_cursor_if
// Video bus between the VGA timing generator / DAC side and the cursor block.
//   blank  : high outside the active video area
//   hcount : current pixel column
//   vcount : current pixel row
//   r/g/b  : registered colour towards the DAC pins
// master = timing generator side, slave = cursor block.
// -----------------------------------------------------------------------------
interface vga_block_cursor_if;
    import vga_cursor_pkg::*;

    logic             blank;
    logic [10:0]      hcount;
    logic [10:0]      vcount;
    logic [RGB_W-1:0] r;
    logic [RGB_W-1:0] g;
    logic [RGB_W-1:0] b;

    modport master (output blank, hcount, vcount, input r, g, b);
    modport slave  (input blank, hcount, vcount, output r, g, b);

endinterface

// File: rtl/vga_block_cursor_btn.sv
// -----------------------------------------------------------------------------
// btn_conditioner
// Turns one raw push-button level into a clean level and a step strobe.
//   clk, reset_n : clock, asynchronous active-low reset
//   btn_raw      : asynchronous raw button level
//   level        : debounced button level
//   step         : one-cycle strobe on the debounced press, then auto-repeat
// A button found held when reset ends is ignored until it has been seen
// released, so a press must start after reset to count.
// -----------------------------------------------------------------------------
module btn_conditioner
    import vga_cursor_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int REPEAT_DELAY    = 25000000,
    parameter int REPEAT_RATE     = 5000000
) (
    input  logic clk,
    input  logic reset_n,
    input  logic btn_raw,
    output logic level,
    output logic step
);

    localparam int DB_W    = clog2(DEBOUNCE_CYCLES + 1);
    localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int RPT_W   = clog2(RPT_MAX + 1);

    logic [1:0]       syncFf;
    logic [1:0]       fill;      // marks when syncFf[1] holds a real sample
    logic             armed;     // set once the button has been seen released
    logic             dbIn;
    logic [DB_W-1:0]  dbCnt;
    logic             levelDly;
    logic [RPT_W-1:0] rptCnt;    // cycles since the last strobe
    logic             rptPhase;  // 0: waiting out the delay, 1: repeating at rate
    logic             rise;
    logic             fire;

    assign dbIn = armed & syncFf[1];
    assign rise = level & ~levelDly;

    always_comb begin
        // NOTE: every combinational output gets a default first so no latch is inferred.
        fire = 1'b0;
        if (REPEAT_DELAY > 0 && level && !rise) begin
            fire = rptPhase ? (rptCnt == RPT_W'(REPEAT_RATE))
                            : (rptCnt == RPT_W'(REPEAT_DELAY));
        end
    end

    assign step = rise | fire;

    // NOTE: sequential state uses non-blocking assignments so all flops sample together.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            syncFf   <= '0;
            fill     <= '0;
            armed    <= 1'b0;
            dbCnt    <= '0;
            level    <= 1'b0;
            levelDly <= 1'b0;
            rptCnt   <= '0;
            rptPhase <= 1'b0;
        end else begin
            syncFf   <= {syncFf[0], btn_raw};
            fill     <= {fill[0], 1'b1};
            armed    <= armed | (fill[1] & ~syncFf[1]);
            levelDly <= level;

            // Accept a new level only after it has been stable long enough.
            if (dbIn == level) begin
                dbCnt <= '0;
            end else if (dbCnt == DB_W'(DEBOUNCE_CYCLES - 1)) begin
                level <= dbIn;
                dbCnt <= '0;
            end else begin
                dbCnt <= dbCnt + 1'b1;
            end

            if (!level) begin
                rptCnt   <= '0;
                rptPhase <= 1'b0;
            end else if (step) begin
                rptCnt   <= RPT_W'(1);
                rptPhase <= fire;
            end else begin
                rptCnt   <= rptCnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/vga_block_cursor.sv
// -----------------------------------------------------------------------------
// vga_block_cursor
// Moves one highlighted cell over a COLS x ROWS grid of 2^CELL_LOG2-pixel
// cells under control of four buttons, and colours the video stream.
//   clk, reset_n           : pixel clock, asynchronous active-low reset
//   uBtn/dBtn/lBtn/rBtn    : raw button levels
//   vid (slave)            : blank/hcount/vcount in, registered r/g/b out
//   hPos, vPos             : cursor column / row
//   moved                  : one-cycle pulse while a new position is first shown
// -----------------------------------------------------------------------------
module vga_block_cursor
    import vga_cursor_pkg::*;
#(
    parameter int          COLS            = 20,
    parameter int          ROWS            = 15,
    parameter int          CELL_LOG2       = 5,
    parameter int          DEBOUNCE_CYCLES = 500000,
    parameter int          REPEAT_DELAY    = 25000000,
    parameter int          REPEAT_RATE     = 5000000,
    parameter int          WRAP            = 0,
    parameter logic [11:0] FG_RGB          = 12'hFFF,
    parameter logic [11:0] BORDER_RGB      = 12'hF00,
    parameter logic [11:0] BG_RGB          = 12'h000
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   uBtn,
    input  logic                   dBtn,
    input  logic                   lBtn,
    input  logic                   rBtn,
    vga_block_cursor_if.slave      vid,
    output logic [clog2(COLS)-1:0] hPos,
    output logic [clog2(ROWS)-1:0] vPos,
    output logic                   moved
);

    localparam int H_W = clog2(COLS);
    localparam int V_W = clog2(ROWS);

    logic [3:0] btnRaw;
    logic [3:0] btnStep;
    logic [3:0] unusedLevel;

    assign btnRaw[DIR_UP]    = uBtn;
    assign btnRaw[DIR_DOWN]  = dBtn;
    assign btnRaw[DIR_LEFT]  = lBtn;
    assign btnRaw[DIR_RIGHT] = rBtn;

    for (genvar i = 0; i < 4; i++) begin : gBtn
        btn_conditioner #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .REPEAT_DELAY   (REPEAT_DELAY),
            .REPEAT_RATE    (REPEAT_RATE)
        ) uCond (
            .clk    (clk),
            .reset_n(reset_n),
            .btn_raw(btnRaw[i]),
            .level  (unusedLevel[i]),
            .step   (btnStep[i])
        );
    end

    // Fixed priority; losing strobes in the same cycle are simply dropped.
    dir_t dir;
    always_comb begin
        dir = DIR_NONE;
        if      (btnStep[DIR_UP])    dir = DIR_UP;
        else if (btnStep[DIR_DOWN])  dir = DIR_DOWN;
        else if (btnStep[DIR_LEFT])  dir = DIR_LEFT;
        else if (btnStep[DIR_RIGHT]) dir = DIR_RIGHT;
    end

    logic [H_W-1:0] hNext;
    logic [V_W-1:0] vNext;
    always_comb begin
        hNext = hPos;
        vNext = vPos;
        case (dir)
            DIR_UP:    if (vPos != '0)               vNext = vPos - 1'b1;
                       else if (WRAP != 0)           vNext = V_W'(ROWS - 1);
            DIR_DOWN:  if (vPos != V_W'(ROWS - 1))   vNext = vPos + 1'b1;
                       else if (WRAP != 0)           vNext = '0;
            DIR_LEFT:  if (hPos != '0)               hNext = hPos - 1'b1;
                       else if (WRAP != 0)           hNext = H_W'(COLS - 1);
            DIR_RIGHT: if (hPos != H_W'(COLS - 1))   hNext = hPos + 1'b1;
                       else if (WRAP != 0)           hNext = '0;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hPos  <= '0;
            vPos  <= '0;
            moved <= 1'b0;
        end else begin
            hPos  <= hNext;
            vPos  <= vNext;
            moved <= (hNext != hPos) || (vNext != vPos);
        end
    end

    // Pixel classification against the position registered at this same edge.
    logic [10:0]          col;
    logic [10:0]          row;
    logic [CELL_LOG2-1:0] subH;
    logic [CELL_LOG2-1:0] subV;
    logic                 inGrid;
    logic                 isCursor;
    logic                 onEdge;
    rgb_t                 rgbNext;

    assign col      = vid.hcount >> CELL_LOG2;
    assign row      = vid.vcount >> CELL_LOG2;
    assign subH     = vid.hcount[CELL_LOG2-1:0];
    assign subV     = vid.vcount[CELL_LOG2-1:0];
    assign inGrid   = (col < 11'(COLS)) && (row < 11'(ROWS));
    assign isCursor = inGrid && (col == 11'(hPos)) && (row == 11'(vPos));
    assign onEdge   = (subH == '0) || (subH == '1) || (subV == '0) || (subV == '1);

    always_comb begin
        rgbNext = '0;
        if (vid.blank)                 rgbNext = '0;
        else if (isCursor && onEdge)   rgbNext = rgb_t'(BORDER_RGB);
        else if (isCursor)             rgbNext = rgb_t'(FG_RGB);
        else if (inGrid)               rgbNext = rgb_t'(BG_RGB);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            vid.r <= '0;
            vid.g <= '0;
            vid.b <= '0;
        end else begin
            vid.r <= rgbNext.r;
            vid.g <= rgbNext.g;
            vid.b <= rgbNext.b;
        end
    end

endmodule

// File: tb/tb_vga_block_cursor.sv
// -----------------------------------------------------------------------------
// tb_vga_block_cursor
// Three cursor instances share buttons, reset and video timing:
//   u0 : clamp edges, auto-repeat on   (scoreboarded on every move and pixel)
//   u1 : wrap edges,  auto-repeat on
//   u2 : clamp edges, auto-repeat off
// Expected moves and pixel colours are queued by the stimulus; a monitor
// on the falling edge pops and compares whenever u0 presents them.
// -----------------------------------------------------------------------------
module tb_vga_block_cursor;
    import vga_cursor_pkg::*;

    localparam logic [11:0] FG     = 12'hFFF;
    localparam logic [11:0] BORDER = 12'hF00;
    localparam logic [11:0] BG     = 12'h05A;

    localparam int BTN_U = 0;
    localparam int BTN_D = 1;
    localparam int BTN_L = 2;
    localparam int BTN_R = 3;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        uBtn = 1'b0, dBtn = 1'b0, lBtn = 1'b0, rBtn = 1'b0;
    logic        blank = 1'b1;
    logic [10:0] hcount = '0, vcount = '0;

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int moves1 = 0;

    always @(posedge clk) cyc <= cyc + 1;

    vga_block_cursor_if vif0 ();
    vga_block_cursor_if vif1 ();
    vga_block_cursor_if vif2 ();

    assign vif0.blank = blank;  assign vif0.hcount = hcount;  assign vif0.vcount = vcount;
    assign vif1.blank = blank;  assign vif1.hcount = hcount;  assign vif1.vcount = vcount;
    assign vif2.blank = blank;  assign vif2.hcount = hcount;  assign vif2.vcount = vcount;

    logic [4:0] hPos0, hPos1, hPos2;
    logic [3:0] vPos0, vPos1, vPos2;
    logic       moved0, moved1, moved2;

    vga_block_cursor #(.DEBOUNCE_CYCLES(4), .REPEAT_DELAY(20), .REPEAT_RATE(5), .WRAP(0),
                       .FG_RGB(FG), .BORDER_RGB(BORDER), .BG_RGB(BG)) u0 (
        .clk(clk), .reset_n(reset_n), .uBtn(uBtn), .dBtn(dBtn), .lBtn(lBtn), .rBtn(rBtn),
        .vid(vif0.slave), .hPos(hPos0), .vPos(vPos0), .moved(moved0));

    vga_block_cursor #(.DEBOUNCE_CYCLES(4), .REPEAT_DELAY(20), .REPEAT_RATE(5), .WRAP(1),
                       .FG_RGB(FG), .BORDER_RGB(BORDER), .BG_RGB(BG)) u1 (
        .clk(clk), .reset_n(reset_n), .uBtn(uBtn), .dBtn(dBtn), .lBtn(lBtn), .rBtn(rBtn),
        .vid(vif1.slave), .hPos(hPos1), .vPos(vPos1), .moved(moved1));

    vga_block_cursor #(.DEBOUNCE_CYCLES(4), .REPEAT_DELAY(0), .REPEAT_RATE(5), .WRAP(0),
                       .FG_RGB(FG), .BORDER_RGB(BORDER), .BG_RGB(BG)) u2 (
        .clk(clk), .reset_n(reset_n), .uBtn(uBtn), .dBtn(dBtn), .lBtn(lBtn), .rBtn(rBtn),
        .vid(vif2.slave), .hPos(hPos2), .vPos(vPos2), .moved(moved2));

    typedef struct {
        logic [4:0] h;
        logic [3:0] v;
    } pos_t;

    typedef struct {
        int          due;
        logic [11:0] rgb;
        string       name;
    } pix_t;

    pos_t moveQ[$];
    pix_t pixQ[$];
    pos_t mPos;
    pix_t mPix;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Monitor: compares u0's moves and colours against the queued expectations.
    always @(negedge clk) begin
        if (moved1) moves1++;
        if (moved0) begin
            if (moveQ.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_move: got h=%0d v=%0d, expected no move", hPos0, vPos0);
            end else begin
                mPos = moveQ.pop_front();
                check("move_h", 32'(hPos0), 32'(mPos.h));
                check("move_v", 32'(vPos0), 32'(mPos.v));
            end
        end
        if (pixQ.size() > 0 && pixQ[0].due == cyc) begin
            mPix = pixQ.pop_front();
            check(mPix.name, 32'({vif0.r, vif0.g, vif0.b}), 32'(mPix.rgb));
        end
    end

    task automatic waitCycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic expectMove(input int h, input int v);
        pos_t p;
        p.h = 5'(h);
        p.v = 4'(v);
        moveQ.push_back(p);
    endtask

    task automatic setBtn(input int which, input logic val);
        case (which)
            BTN_U:   uBtn = val;
            BTN_D:   dBtn = val;
            BTN_L:   lBtn = val;
            default: rBtn = val;
        endcase
    endtask

    // A hold of 8 cycles is well short of the repeat delay: exactly one step.
    task automatic pressBtn(input int which);
        @(negedge clk);
        setBtn(which, 1'b1);
        waitCycles(8);
        setBtn(which, 1'b0);
        waitCycles(14);
    endtask

    task automatic doReset();
        @(negedge clk);
        reset_n = 1'b0;
        waitCycles(3);
        reset_n = 1'b1;
        waitCycles(3);
    endtask

    task automatic pix(input string name, input int h, input int v, input logic bl,
                       input logic [11:0] exp);
        pix_t p;
        @(posedge clk);
        #1;
        hcount = 11'(h);
        vcount = 11'(v);
        blank  = bl;
        p.due  = cyc + 1;
        p.rgb  = exp;
        p.name = name;
        pixQ.push_back(p);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int m1;

        // ---- reset state
        waitCycles(2);
        check("reset_h",     32'(hPos0), 0);
        check("reset_v",     32'(vPos0), 0);
        check("reset_moved", 32'(moved0), 0);
        check("reset_rgb",   32'({vif0.r, vif0.g, vif0.b}), 0);
        @(negedge clk);
        reset_n = 1'b1;
        waitCycles(4);

        // ---- debounce: 2-cycle toggling never settles, then a clean hold steps once
        expectMove(1, 0);
        for (int i = 0; i < 10; i++) begin
            rBtn = 1'b1; waitCycles(2);
            rBtn = 1'b0; waitCycles(2);
        end
        rBtn = 1'b1; waitCycles(10);
        rBtn = 1'b0; waitCycles(14);
        check("debounce_h", 32'(hPos0), 1);

        // ---- asynchronous reset mid-hold
        hcount = 11'd64; vcount = 11'd0; blank = 1'b0;
        expectMove(2, 0);
        rBtn = 1'b1;
        waitCycles(10);
        check("prereset_rgb", 32'({vif0.r, vif0.g, vif0.b}), 32'(BORDER));
        @(posedge clk);
        #3;
        reset_n = 1'b0;
        #1;
        check("async_reset_h",   32'(hPos0), 0);
        check("async_reset_v",   32'(vPos0), 0);
        check("async_reset_rgb", 32'({vif0.r, vif0.g, vif0.b}), 0);
        blank = 1'b1;
        waitCycles(3);
        @(negedge clk);
        reset_n = 1'b1;
        waitCycles(25);
        check("held_through_reset_h", 32'(hPos0), 0);
        rBtn = 1'b0;
        waitCycles(14);
        expectMove(1, 0);
        pressBtn(BTN_R);
        check("repress_h", 32'(hPos0), 1);

        // ---- auto-repeat: steps land 7, 27, 32, ..., 57 cycles after the press
        for (int i = 1; i <= 9; i++) expectMove(1, i);
        @(negedge clk);
        dBtn = 1'b1;
        waitCycles(60);
        check("repeat_v_at_60", 32'(vPos0), 8);
        dBtn = 1'b0;
        // The release is itself debounced, so one more repeat lands before it takes effect.
        waitCycles(14);
        check("repeat_v_final", 32'(vPos0), 9);
        check("norepeat_v",     32'(vPos2), 1);

        // ---- edges: 19 steps from column 0 reach the last column
        doReset();
        for (int i = 1; i <= 19; i++) expectMove(i, 0);
        @(negedge clk);
        rBtn = 1'b1;
        waitCycles(108);
        rBtn = 1'b0;
        waitCycles(14);
        check("clamp_reach_h", 32'(hPos0), 19);
        check("wrap_reach_h",  32'(hPos1), 19);
        check("norpt_reach_h", 32'(hPos2), 1);
        m1 = moves1;
        pressBtn(BTN_R);
        check("clamp_right_h",  32'(hPos0), 19);
        check("wrap_right_h",   32'(hPos1), 0);
        check("wrap_moved_cnt", 32'(moves1 - m1), 1);

        // ---- priority: up beats left in the same cycle, left is dropped
        doReset();
        for (int i = 1; i <= 5; i++) begin expectMove(i, 0); pressBtn(BTN_R); end
        for (int i = 1; i <= 5; i++) begin expectMove(5, i); pressBtn(BTN_D); end
        expectMove(5, 4);
        @(negedge clk);
        uBtn = 1'b1; lBtn = 1'b1;
        waitCycles(8);
        uBtn = 1'b0; lBtn = 1'b0;
        waitCycles(20);
        check("prio_h", 32'(hPos0), 5);
        check("prio_v", 32'(vPos0), 4);

        // ---- pixels with the cursor at (1,2)
        doReset();
        expectMove(1, 0); pressBtn(BTN_R);
        expectMove(1, 1); pressBtn(BTN_D);
        expectMove(1, 2); pressBtn(BTN_D);
        pix("pix_border_tl",   32,  64, 1'b0, BORDER);
        pix("pix_fill",        40,  70, 1'b0, FG);
        pix("pix_bg_right",    64,  70, 1'b0, BG);
        pix("pix_outside_col", 640, 70, 1'b0, 12'h000);
        pix("pix_blank",       40,  70, 1'b1, 12'h000);
        pix("pix_border_br",   63,  95, 1'b0, BORDER);
        pix("pix_bg_below",    40,  96, 1'b0, BG);
        pix("pix_bg_left",     31,  70, 1'b0, BG);
        pix("pix_outside_row", 40, 480, 1'b0, 12'h000);
        @(posedge clk);
        #1;
        blank = 1'b1;
        waitCycles(4);

        check("moves_outstanding",  32'(moveQ.size()), 0);
        check("pixels_outstanding", 32'(pixQ.size()), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/vga_block_cursor.md
Name: vga_block_cursor

Overview:
Parametrised successor of the single-block VGA mover. It moves one highlighted cell over a COLS x ROWS grid of 2^CELL_LOG2-pixel square cells, driven by four push buttons. Each button is synchronised, debounced and given hold-to-auto-repeat. Grid edges either clamp or wrap, selected by parameter. It sits between the VGA timing generator (hcount/vcount/blank) and the DAC colour pins, and outputs registered 4:4:4 RGB plus the cursor position.

Parameters:
COLS, 20, grid columns (>=2)
ROWS, 15, grid rows (>=2)
CELL_LOG2, 5, log2 of cell edge in pixels (5 -> 32 px)
DEBOUNCE_CYCLES, 500000, cycles a synchronised button level must be stable before it is accepted (>=1)
REPEAT_DELAY, 25000000, cycles held after the first step before auto-repeat starts; 0 disables repeat
REPEAT_RATE, 5000000, cycles between repeat steps (>=1)
WRAP, 0, 0 = clamp at grid edges, 1 = wrap to the opposite edge
FG_RGB, 12'hFFF, fill colour of the cursor cell {r,g,b}
BORDER_RGB, 12'hF00, colour of the 1-px cursor outline
BG_RGB, 12'h000, colour of in-grid non-cursor pixels

Ports:
clk  in  1  pixel/system clock
reset_n  in  1  asynchronous, active-low reset
uBtn  in  1  up button, asynchronous raw level
dBtn  in  1  down button, asynchronous raw level
lBtn  in  1  left button, asynchronous raw level
rBtn  in  1  right button, asynchronous raw level
blank  in  1  high outside the active video area
hcount  in  11  current pixel column
vcount  in  11  current pixel row
hPos  out  $clog2(COLS)  cursor column
vPos  out  $clog2(ROWS)  cursor row
moved  out  1  one-cycle pulse in the cycle after hPos/vPos change
r  out  4  red
g  out  4  green
b  out  4  blue

Behaviour:
- Reset (reset_n low, asynchronous): hPos=0, vPos=0, moved=0, r=g=b=0. All synchronisers, debouncers and repeat counters clear; every button reads as released.
- Button path, per button: 2-flop synchroniser, then debounce. The debounced level changes only after DEBOUNCE_CYCLES consecutive cycles at the new synchronised level.
- Step strobe, per button:
  - One-cycle strobe on the debounced rising edge.
  - If REPEAT_DELAY>0 and the button is still held: further strobe REPEAT_DELAY cycles after the first, then every REPEAT_RATE cycles.
  - Release clears the repeat counter immediately.
- Arbitration: at most one step per cycle, priority up > down > left > right. Lower-priority strobes in the same cycle are discarded, not queued.
- Step application:
  - Registered; hPos/vPos update on the clock edge after the strobe.
  - Up decrements vPos, down increments vPos, left decrements hPos, right increments hPos.
- Edges:
  - WRAP=0: a step at row 0 up, row ROWS-1 down, column 0 left or column COLS-1 right leaves the position unchanged and does not pulse moved.
  - WRAP=1: up at row 0 goes to ROWS-1, down at ROWS-1 goes to 0; columns wrap the same way. moved pulses.
- moved is high for exactly one cycle per position change.
- Pixel classification, combinational on the inputs:
  - col = hcount>>CELL_LOG2, row = vcount>>CELL_LOG2.
  - in_grid = col<COLS && row<ROWS.
  - cursor = in_grid && col==hPos && row==vPos.
  - edge = low CELL_LOG2 bits of hcount or vcount are all-0 or all-1.
- Colour priority, registered (1-cycle latency from hcount/vcount/blank to r/g/b):
  - blank gives 0.
  - Otherwise cursor&&edge gives BORDER_RGB.
  - Otherwise cursor gives FG_RGB.
  - Otherwise in_grid gives BG_RGB.
  - Otherwise 0.
- Cell extent is exactly 2^CELL_LOG2 pixels, [k*2^CELL_LOG2, (k+1)*2^CELL_LOG2-1], with no 1-pixel overlap into the neighbouring cell.
- Colour uses the hPos/vPos value registered at the same edge, so a move may appear mid-frame. Frame-synchronous update is out of scope.

Decomposition:
- Package vga_cursor_pkg: RGB_W=4, the 12-bit colour layout {r,g,b}, direction enum (DIR_UP, DIR_DOWN, DIR_LEFT, DIR_RIGHT, DIR_NONE), and a clog2 helper.
- Sub-module btn_conditioner (parameters DEBOUNCE_CYCLES, REPEAT_DELAY, REPEAT_RATE; ports clk, reset_n, btn_raw, level, step). Instantiated four times.
- Arbitration, position registers and pixel pipeline live in the top.

Test Plan:
- Bench uses DEBOUNCE_CYCLES=4, REPEAT_DELAY=20, REPEAT_RATE=5.
- Reset: reset_n low mid-operation with rBtn held -> hPos=0, vPos=0, r/g/b=0 immediately; no step until rBtn is released and pressed again after reset_n rises.
- Debounce: rBtn toggles every 2 cycles for 40 cycles, then holds high 10 cycles -> exactly one step, hPos 0->1; moved pulses once.
- Auto-repeat: dBtn held 60 cycles from vPos=0 -> steps at about t+6, t+26, t+31, t+36, ... giving vPos=8. Repeat with REPEAT_DELAY=0 -> vPos=1.
- Edges: WRAP=0, hPos=19, press rBtn -> hPos stays 19, no moved pulse. WRAP=1, same press -> hPos=0, moved pulses.
- Priority: uBtn and lBtn debounced on the same cycle at (5,5) -> (5,4) only. lBtn's strobe is discarded, not applied on a later cycle.
- Pixels: cursor at (1,2), blank=0:
  - hcount=32, vcount=64 -> r/g/b = BORDER_RGB one cycle later.
  - (40,70) -> FG_RGB.
  - (64,70) -> BG_RGB.
  - (640,70) -> 0.
  - blank=1 -> 0.
